// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R      = 4'd0,
    C_IALU   = 4'd1,
    C_LOAD   = 4'd2,
    C_STORE  = 4'd3,
    C_BRANCH = 4'd4,
    C_JAL    = 4'd5,
    C_JALR   = 4'd6,
    C_LUI    = 4'd7,
    C_AUIPC  = 4'd8,
    C_ILL    = 4'd9
  } iclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_AND   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_IMEM = 2'b10;
  localparam logic [1:0] CAUSE_DMEM = 2'b11;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/ctrl_fsm_insn_decode.sv
// Combinational classification of the latched instruction into class and datapath selects.
module insn_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output iclass_t    iclass,
  output logic [3:0] alu_op,
  output logic       opa_sel,
  output logic       opb_sel,
  output logic       br_un,
  output logic       illegal,
  output logic       br_bad
);

  // funct7[5] only matters for SUB (register form) and SRA
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt,
                                                input logic allow_sub);
    case (f3)
      3'b000:  alu_from_funct = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_funct = ALU_SLL;
      3'b010:  alu_from_funct = ALU_SLT;
      3'b011:  alu_from_funct = ALU_SLTU;
      3'b100:  alu_from_funct = ALU_XOR;
      3'b101:  alu_from_funct = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_funct = ALU_OR;
      3'b111:  alu_from_funct = ALU_AND;
      default: alu_from_funct = ALU_ADD;
    endcase
  endfunction

  // opcode classification
  always_comb begin
    iclass  = C_ILL;
    alu_op  = ALU_ADD;
    opa_sel = 1'b0;
    opb_sel = 1'b0;
    br_un   = 1'b0;
    illegal = 1'b0;
    br_bad  = 1'b0;
    case (opcode)
      OP_R: begin
        iclass  = C_R;
        opb_sel = 1'b1;
        alu_op  = alu_from_funct(funct3, funct7b5, 1'b1);
      end
      OP_IALU: begin
        iclass = C_IALU;
        alu_op = alu_from_funct(funct3, funct7b5, 1'b0);
      end
      OP_LOAD:  iclass = C_LOAD;
      OP_STORE: iclass = C_STORE;
      OP_BRANCH: begin
        iclass  = C_BRANCH;
        opa_sel = 1'b1;
        br_un   = funct3[2] & funct3[1];
        br_bad  = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        iclass  = C_JAL;
        opa_sel = 1'b1;
      end
      OP_JALR: iclass = C_JALR;
      OP_LUI: begin
        iclass = C_LUI;
        alu_op = ALU_PASSB;
      end
      OP_AUIPC: begin
        iclass  = C_AUIPC;
        opa_sel = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with ack timeouts and a sticky trap.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                br_less,
  input  logic                br_equal,
  output logic                imem_req,
  output logic [31:0]         ir_o,
  output logic                pc_wren,
  output logic                pc_sel,
  output logic                rd_wren,
  output logic                br_un,
  output logic                opa_sel,
  output logic                opb_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_rden,
  output logic                mem_wren,
  output logic [1:0]          wb_sel,
  output logic                insn_vld,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_t          state_r, state_nx;
  logic [31:0]     ir_r;
  logic [TO_W-1:0] cnt_r, cnt_nx, cnt_inc_s;
  logic [1:0]      cause_r, cause_nx;
  logic            load_ir_s, timeout_s, taken_s;

  iclass_t         iclass_s;
  logic [3:0]      dec_alu_s;
  logic            dec_opa_s, dec_opb_s, dec_bun_s, dec_ill_s, dec_brbad_s;

  logic            imem_req_s, pc_wren_s, pc_sel_s, rd_wren_s, dp_en_s;
  logic            mem_rden_s, mem_wren_s, insn_vld_s;
  logic [1:0]      wb_sel_s;

  insn_decode u_decode (
    .opcode   (ir_r[6:0]),
    .funct3   (ir_r[14:12]),
    .funct7b5 (ir_r[30]),
    .iclass   (iclass_s),
    .alu_op   (dec_alu_s),
    .opa_sel  (dec_opa_s),
    .opb_sel  (dec_opb_s),
    .br_un    (dec_bun_s),
    .illegal  (dec_ill_s),
    .br_bad   (dec_brbad_s)
  );

  // An ack in the cycle the count would reach MEM_TIMEOUT is checked first and wins
  assign cnt_inc_s = cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
  assign timeout_s = (cnt_inc_s == TO_W'(MEM_TIMEOUT));

  // state, instruction register, wait counter and trap cause
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FETCH;
      ir_r    <= NOP_INSN;
      cnt_r   <= {TO_W{1'b0}};
      cause_r <= CAUSE_NONE;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      cause_r <= cause_nx;
      if (load_ir_s) begin
        ir_r <= imem_rdata;
      end
    end
  end

  // branch condition from funct3 and the comparator flags
  always_comb begin
    case (ir_r[14:12])
      3'b000:         taken_s = br_equal;
      3'b001:         taken_s = ~br_equal;
      3'b100, 3'b110: taken_s = br_less;
      3'b101, 3'b111: taken_s = ~br_less;
      default:        taken_s = 1'b0;
    endcase
  end

  // next state and strobes
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = {TO_W{1'b0}};
    cause_nx   = cause_r;
    load_ir_s  = 1'b0;
    imem_req_s = 1'b0;
    pc_wren_s  = 1'b0;
    pc_sel_s   = 1'b0;
    rd_wren_s  = 1'b0;
    dp_en_s    = 1'b0;
    mem_rden_s = 1'b0;
    mem_wren_s = 1'b0;
    insn_vld_s = 1'b0;
    wb_sel_s   = WB_MEM;
    case (state_r)
      FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          load_ir_s = 1'b1;
          state_nx  = DECODE;
        end else if (timeout_s) begin
          state_nx = TRAP;
          cause_nx = CAUSE_IMEM;
        end else begin
          cnt_nx = cnt_inc_s;
        end
      end
      DECODE: begin
        if (dec_ill_s) begin
          state_nx = TRAP;
          cause_nx = CAUSE_ILL;
        end else begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        dp_en_s = 1'b1;
        case (iclass_s)
          C_LOAD, C_STORE: state_nx = MEM;
          C_BRANCH: begin
            if (dec_brbad_s) begin
              state_nx = TRAP;
              cause_nx = CAUSE_ILL;
            end else begin
              pc_wren_s  = 1'b1;
              pc_sel_s   = taken_s;
              insn_vld_s = 1'b1;
              state_nx   = FETCH;
            end
          end
          C_ILL: begin
            state_nx = TRAP;
            cause_nx = CAUSE_ILL;
          end
          default: state_nx = WB;
        endcase
      end
      MEM: begin
        dp_en_s = 1'b1;
        if (iclass_s == C_STORE) begin
          mem_wren_s = 1'b1;
        end else begin
          mem_rden_s = 1'b1;
        end
        if (dmem_ack) begin
          if (iclass_s == C_STORE) begin
            pc_wren_s  = 1'b1;
            insn_vld_s = 1'b1;
            state_nx   = FETCH;
          end else begin
            state_nx = WB;
          end
        end else if (timeout_s) begin
          state_nx = TRAP;
          cause_nx = CAUSE_DMEM;
        end else begin
          cnt_nx = cnt_inc_s;
        end
      end
      WB: begin
        dp_en_s    = 1'b1;
        rd_wren_s  = 1'b1;
        pc_wren_s  = 1'b1;
        insn_vld_s = 1'b1;
        state_nx   = FETCH;
        case (iclass_s)
          C_LOAD:         wb_sel_s = WB_MEM;
          C_JAL, C_JALR: begin
            wb_sel_s = WB_PC4;
            pc_sel_s = 1'b1;
          end
          default:        wb_sel_s = WB_ALU;
        endcase
      end
      TRAP:    state_nx = TRAP;
      default: state_nx = FETCH;
    endcase
  end

  // every output except ir_o is forced low while reset is asserted
  assign imem_req   = rst_n & imem_req_s;
  assign ir_o       = ir_r;
  assign pc_wren    = rst_n & pc_wren_s;
  assign pc_sel     = rst_n & pc_sel_s;
  assign rd_wren    = rst_n & rd_wren_s;
  assign br_un      = rst_n & dp_en_s & dec_bun_s;
  assign opa_sel    = rst_n & dp_en_s & dec_opa_s;
  assign opb_sel    = rst_n & dp_en_s & dec_opb_s;
  assign alu_op     = (rst_n && dp_en_s) ? ALU_OP_W'(dec_alu_s) : {ALU_OP_W{1'b0}};
  assign mem_rden   = rst_n & mem_rden_s;
  assign mem_wren   = rst_n & mem_wren_s;
  assign wb_sel     = rst_n ? wb_sel_s : 2'b00;
  assign insn_vld   = rst_n & insn_vld_s;
  assign trap       = rst_n & (state_r == TRAP);
  assign trap_cause = rst_n ? cause_r : 2'b00;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed cases plus random instructions against a cycle-count model.
module tb_ctrl_fsm;

  localparam int MEM_TO = 15;

  logic        clk, rst_n;
  logic [31:0] imem_rdata;
  logic        imem_ack, dmem_ack, br_less, br_equal;
  logic        imem_req, pc_wren, pc_sel, rd_wren, br_un, opa_sel, opb_sel;
  logic [31:0] ir_o;
  logic [3:0]  alu_op;
  logic        mem_rden, mem_wren, insn_vld, trap;
  logic [1:0]  wb_sel, trap_cause;

  int tests = 0;
  int fails = 0;

  ctrl_fsm #(.ALU_OP_W(4), .MEM_TIMEOUT(MEM_TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .br_less(br_less), .br_equal(br_equal),
    .imem_req(imem_req), .ir_o(ir_o), .pc_wren(pc_wren), .pc_sel(pc_sel),
    .rd_wren(rd_wren), .br_un(br_un), .opa_sel(opa_sel), .opb_sel(opb_sel),
    .alu_op(alu_op), .mem_rden(mem_rden), .mem_wren(mem_wren), .wb_sel(wb_sel),
    .insn_vld(insn_vld), .trap(trap), .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] out_vec;
  logic [5:0]  strobes;
  assign out_vec = {imem_req, pc_wren, pc_sel, rd_wren, br_un, opa_sel, opb_sel, alu_op,
                    mem_rden, mem_wren, wb_sel, insn_vld, trap, trap_cause};
  assign strobes = {imem_req, pc_wren, rd_wren, mem_rden, mem_wren, insn_vld};

  typedef struct {
    int         lat;
    bit         trp;
    logic [1:0] cause;
    bit         rd;
    logic [1:0] wb;
    bit         psel;
    bit         opa;
    bit         opb;
    logic [3:0] alu;
    bit         bun;
    int         rc;
    int         wc;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ALU operation from the RV32I funct3 table
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input bit alt, input bit is_reg);
    logic [3:0] tab [8];
    tab = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6};
    if (f3 == 3'd0 && alt && is_reg) return 4'd1;
    if (f3 == 3'd5 && alt) return 4'd9;
    return tab[f3];
  endfunction

  // Expected retire/trap behaviour, counted in cycles from the first FETCH cycle
  function automatic exp_t model(input logic [31:0] insn, input int iw, input int dw,
                                 input bit eq, input bit lt);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    bit alt;
    e = '{default: 0};
    op = insn[6:0];
    f3 = insn[14:12];
    alt = insn[30];
    if (iw >= MEM_TO) begin
      e.trp = 1; e.cause = 2'b10; e.lat = MEM_TO + 1;
      return e;
    end
    case (op)
      7'b0110011: begin e.lat = iw + 4; e.rd = 1; e.wb = 2'b01; e.opb = 1; e.alu = alu_of(f3, alt, 1); end
      7'b0010011: begin e.lat = iw + 4; e.rd = 1; e.wb = 2'b01; e.alu = alu_of(f3, alt, 0); end
      7'b0110111: begin e.lat = iw + 4; e.rd = 1; e.wb = 2'b01; e.alu = 4'd10; end
      7'b0010111: begin e.lat = iw + 4; e.rd = 1; e.wb = 2'b01; e.opa = 1; end
      7'b1101111: begin e.lat = iw + 4; e.rd = 1; e.wb = 2'b10; e.psel = 1; e.opa = 1; end
      7'b1100111: begin e.lat = iw + 4; e.rd = 1; e.wb = 2'b10; e.psel = 1; end
      7'b0000011, 7'b0100011: begin
        if (dw >= MEM_TO) begin
          e.trp = 1; e.cause = 2'b11; e.lat = iw + 4 + MEM_TO;
        end else if (op[5]) begin
          e.lat = iw + 4 + dw; e.wc = dw + 1;
        end else begin
          e.lat = iw + 5 + dw; e.rc = dw + 1; e.rd = 1; e.wb = 2'b00;
        end
      end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          e.trp = 1; e.cause = 2'b01; e.lat = iw + 4;
        end else begin
          e.lat = iw + 3; e.opa = 1; e.bun = (f3 >= 3'd6);
          case (f3)
            3'd0:       e.psel = eq;
            3'd1:       e.psel = !eq;
            3'd4, 3'd6: e.psel = lt;
            default:    e.psel = !lt;
          endcase
        end
      end
      default: begin e.trp = 1; e.cause = 2'b01; e.lat = iw + 3; end
    endcase
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    check("rst_gate", out_vec, 19'd0);
    @(negedge clk); #1;
    check("rst_hold", out_vec, 19'd0);
    check("rst_ir", ir_o, 32'h0000_0013);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_fetch", imem_req, 1'b1);
    check("rst_trapclr", {trap, trap_cause}, 3'd0);
  endtask

  task automatic run_insn(input string tag, input logic [31:0] insn, input int iw, input int dw,
                          input bit eq, input bit lt);
    exp_t e;
    int cyc, fcnt, mcnt, rc, wc, lat;
    bit done, tr, rd_o, psel_o, pw_o, opa_o, opb_o, bun_o;
    logic [1:0] cause_o, wb_o;
    logic [3:0] alu_o;
    logic [31:0] ir_s;
    e = model(insn, iw, dw, eq, lt);
    imem_rdata = insn; br_equal = eq; br_less = lt;
    cyc = 0; fcnt = 0; mcnt = 0; rc = 0; wc = 0; lat = 0; done = 0; tr = 0;
    rd_o = 0; psel_o = 0; pw_o = 0; opa_o = 0; opb_o = 0; bun_o = 0;
    cause_o = 2'b00; wb_o = 2'b00; alu_o = 4'd0; ir_s = 32'd0;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      imem_ack = imem_req && (fcnt == iw);
      if (imem_req) fcnt++;
      dmem_ack = (mem_rden || mem_wren) && (mcnt == dw);
      if (mem_rden || mem_wren) mcnt++;
      #1;
      if (mem_rden) rc++;
      if (mem_wren) wc++;
      if (trap) begin
        tr = 1; lat = cyc; cause_o = trap_cause; done = 1;
      end else if (insn_vld) begin
        lat = cyc; rd_o = rd_wren; wb_o = wb_sel; psel_o = pc_sel; pw_o = pc_wren;
        opa_o = opa_sel; opb_o = opb_sel; alu_o = alu_op; bun_o = br_un; ir_s = ir_o;
        done = 1;
      end
    end
    check({tag, ".lat"}, lat, e.lat);
    check({tag, ".trap"}, tr, e.trp);
    if (e.trp) begin
      check({tag, ".cause"}, cause_o, e.cause);
      for (int k = 0; k < 3; k++) begin
        imem_ack = 1'b1; dmem_ack = 1'b1;
        @(negedge clk); #1;
        check({tag, ".absorb"}, {strobes, trap, trap_cause}, {6'd0, 1'b1, e.cause});
      end
      do_reset();
    end else begin
      check({tag, ".rd"}, rd_o, e.rd);
      check({tag, ".wb"}, wb_o, e.wb);
      check({tag, ".psel"}, psel_o, e.psel);
      check({tag, ".pcwr"}, pw_o, 1'b1);
      check({tag, ".opa"}, opa_o, e.opa);
      check({tag, ".opb"}, opb_o, e.opb);
      check({tag, ".alu"}, alu_o, e.alu);
      check({tag, ".brun"}, bun_o, e.bun);
      check({tag, ".rden"}, rc, e.rc);
      check({tag, ".wren"}, wc, e.wc);
      check({tag, ".ir"}, ir_s, insn);
    end
  endtask

  initial begin
    logic [6:0] ops [10];
    logic [31:0] r;
    int idx, iw, dw, cyc;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 32'd0; br_less = 1'b0; br_equal = 1'b0;
    do_reset();

    run_insn("add",     32'h002081B3, 0, 0, 1'b0, 1'b0);
    run_insn("lw",      32'h0080A283, 0, 3, 1'b0, 1'b0);
    run_insn("bne_t",   32'h00209463, 0, 0, 1'b0, 1'b0);
    run_insn("bne_nt",  32'h00209463, 0, 0, 1'b1, 1'b0);
    run_insn("bgeu",    32'h0020F463, 0, 0, 1'b0, 1'b0);
    run_insn("jal",     32'h008000EF, 0, 0, 1'b0, 1'b0);
    run_insn("sw",      32'h0020A223, 1, 2, 1'b0, 1'b0);
    run_insn("sra",     32'h4020D1B3, 0, 0, 1'b0, 1'b0);
    run_insn("srai",    32'h4030D093, 2, 0, 1'b0, 1'b0);
    run_insn("illegal", 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0);
    run_insn("imem_to", 32'h002081B3, MEM_TO, 0, 1'b0, 1'b0);
    run_insn("imem_14", 32'h002081B3, MEM_TO - 1, 0, 1'b0, 1'b0);
    run_insn("dmem_to", 32'h0020A223, 0, MEM_TO, 1'b0, 1'b0);
    run_insn("dmem_14", 32'h0080A283, 0, MEM_TO - 1, 1'b0, 1'b0);
    run_insn("br_f3_2", 32'h0020A463, 0, 0, 1'b0, 1'b0);

    // reset while an SW sits in MEM waiting for its ack
    imem_rdata = 32'h0020A223;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      #1;
      cyc++;
      if (mem_wren) cyc = 100;
    end
    check("sw_reach_mem", cyc, 100);
    do_reset();
    run_insn("after_rst", 32'h00000037, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 9);
      r = $urandom;
      if (idx == 9) r[6:0] = 7'($urandom);
      else r[6:0] = ops[idx];
      iw = ($urandom_range(0, 11) == 0) ? MEM_TO : $urandom_range(0, 3);
      dw = ($urandom_range(0, 11) == 0) ? MEM_TO : $urandom_range(0, 3);
      run_insn("rand", r, iw, dw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
Multi-cycle RV32I control unit, the successor to the single-cycle decoder. It sequences FETCH/DECODE/EXEC/MEM/WB around a shared datapath and latches the fetched word in an internal instruction register. It waits on instruction- and data-memory ack handshakes, with a bounded timeout. Decode coverage is extended to shift-immediates, JAL, JALR, LUI and AUIPC, with taken/not-taken branch resolution and a sticky trap state for illegal opcodes or memory timeout.

Parameters:
ALU_OP_W, 4, width of alu_op; encoding: ADD 0000, SUB 0001, SLT 0010, SLTU 0011, XOR 0100, OR 0101, AND 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010
MEM_TIMEOUT, 15, maximum wait cycles for imem_ack/dmem_ack before trap (1..255)
TO_W, 8, wait-counter width; must satisfy 2**TO_W > MEM_TIMEOUT

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous, active-low reset
imem_rdata  input  32  fetched instruction word
imem_ack  input  1  instruction word valid this cycle
dmem_ack  input  1  data access complete this cycle
br_less  input  1  rs1<rs2, signedness per br_un
br_equal  input  1  rs1==rs2
imem_req  output  1  instruction fetch request
ir_o  output  32  latched instruction register
pc_wren  output  1  PC update strobe
pc_sel  output  1  0: PC+4, 1: ALU result
rd_wren  output  1  register-file write strobe
br_un  output  1  unsigned compare select
opa_sel  output  1  0: rs1, 1: PC
opb_sel  output  1  0: immediate, 1: rs2
alu_op  output  ALU_OP_W  ALU operation
mem_rden  output  1  data read request
mem_wren  output  1  data write request
wb_sel  output  2  00 memory, 01 ALU, 10 PC+4
insn_vld  output  1  one-cycle pulse on instruction retire
trap  output  1  sticky fault flag
trap_cause  output  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout

Behaviour:
- Reset (rst_n low at a rising edge): state=FETCH, ir_o=32'h0000_0013 (NOP), wait counter=0, trap=0, trap_cause=00. While rst_n is low, every output except ir_o is 0. A reset mid-instruction aborts it with no pc_wren or rd_wren.
- Outputs are combinational from the state, ir_o and the branch flags. Non-listed strobes are 0 in every state.
- FETCH: imem_req=1.
  - On imem_ack: ir_o<=imem_rdata, go to DECODE.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT, go to TRAP with cause 10.
  - The counter clears on every state change.
- DECODE: one cycle; classifies the opcode. Unsupported opcodes (not 0110011/0010011/0000011/0100011/1100011/1101111/1100111/0110111/0010111) go to TRAP with cause 01. All others go to EXEC.
- EXEC, by instruction class:
  - R-type: opb_sel=1. funct7[5] selects SUB/SRA. Then go to WB.
  - I-ALU: opb_sel=0. funct3 001 gives SLL; funct3 101 gives SRL or SRA per funct7[5]. Then go to WB.
  - LUI: alu_op=PASSB. Then go to WB.
  - AUIPC: opa_sel=1, ADD. Then go to WB.
  - Load/store: ADD, opb_sel=0, then go to MEM.
  - Branch: opa_sel=1, ADD. Taken condition by funct3:
    - BEQ: equal.
    - BNE: !equal.
    - BLT/BLTU: less.
    - BGE/BGEU: !less.
    - br_un=1 for funct3 110/111.
    - Unlisted funct3 (010/011) gives TRAP with cause 01.
    - pc_wren=1, pc_sel=taken, insn_vld=1, then go to FETCH.
  - JAL: opa_sel=1. JALR: opa_sel=0. Both use ADD and go to WB.
- MEM: mem_rden=1 for loads, mem_wren=1 for stores, held until dmem_ack.
  - Load + ack: go to WB.
  - Store + ack: pc_wren=1, pc_sel=0, insn_vld=1, go to FETCH.
  - Timeout works as in FETCH, giving cause 11.
- WB: rd_wren=1, pc_wren=1, insn_vld=1, then go to FETCH.
  - Loads: wb_sel=00.
  - JAL/JALR: wb_sel=10, pc_sel=1; the ALU recomputes the target in WB with the same operand selects.
  - All other classes: wb_sel=01, pc_sel=0.
- Latencies (ack in the first cycle):
  - Branch: 3 cycles.
  - Store and ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Each additional wait cycle adds 1.
- TRAP: absorbing; all strobes 0, trap=1, trap_cause held. Only reset exits it.
- An ack arriving in the same cycle the counter hits MEM_TIMEOUT wins: no trap.
- An ack outside its wait state is ignored.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - opcode localparams;
  - alu_op encoding constants;
  - wb_sel/trap_cause constants.
- One sub-module, insn_decode: combinational decode of ir_o into class, alu_op, opa/opb_sel, br_un, illegal. The FSM stays in ctrl_fsm.

Test Plan:
- ADD x3,x1,x2 (32'h002081B3), imem_ack immediate: rd_wren and insn_vld in cycle 4; wb_sel=01, alu_op=0000, opb_sel=1.
- LW x5,8(x1) (32'h0080A283), dmem_ack after 3 wait cycles: mem_rden high for 4 cycles; WB has rd_wren=1, wb_sel=00; total 8 cycles.
- BNE 32'h00209463 with br_equal=0, then with br_equal=1: pc_sel=1 and pc_sel=0 respectively, pc_wren=1 in cycle 3. BGEU (funct3 111) with br_less=0: br_un=1, taken.
- JAL 32'h008000EF: WB has wb_sel=10, rd_wren=1, pc_sel=1, opa_sel=1.
- Illegal opcode 32'hFFFFFFFF: TRAP after DECODE, trap=1, cause=01, all strobes 0 until reset. No imem_ack for 15 cycles: TRAP with cause=10. Ack on cycle 15: no trap.
- rst_n low in the MEM state of an SW: no mem_wren or pc_wren in the following cycle; state is FETCH and ir_o=NOP after release.
